// File: rtl/majority_vote_arbiter.sv
// Round-robin arbiter that feeds NREQ ballot sources into one shared 5-bit
// majority evaluator built on an 8-to-1 mux, returning verdict, count and ID.

module mux (
   input  logic [2:0] sel_i,
   input  logic [7:0] d_i,
   output logic       y_o
);
   assign y_o = d_i[sel_i];
endmodule

module majority_vote_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [5*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_out,
   output logic [2:0]        res_count,
   output logic [IDW-1:0]    res_id
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EVAL   = 2'd1;
   localparam logic [1:0] S_RESULT = 2'd2;

   logic [1:0]     state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] id_q, id_d;
   logic [4:0]     vote_q, vote_d;
   logic           res_out_q, res_out_d;
   logic [2:0]     res_count_q, res_count_d;
   logic [IDW-1:0] res_id_q, res_id_d;

   logic           grant_found;
   logic [IDW-1:0] grant_idx;
   logic [7:0]     mux_d;
   logic           mux_y;

   function automatic logic [2:0] popcount5(input logic [4:0] v);
      logic [2:0] c;
      c = '0;
      for (int i = 0; i < 5; i++) begin
         c = c + {2'b00, v[i]};
      end
      return c;
   endfunction

   // Scan starting at ptr_q, wrapping at NREQ; first valid requester wins.
   always_comb begin
      logic [IDW:0]   sum;
      logic [IDW-1:0] idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr_q} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(NREQ)) begin
            sum = sum - (IDW+1)'(NREQ);
         end
         idx = sum[IDW-1:0];
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_idx   = idx;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && grant_found && !reset) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // With three top bits selecting, the two low bits decide the tie cases.
   assign mux_d = {1'b1,
                   vote_q[1] | vote_q[0], vote_q[1] | vote_q[0], vote_q[1] & vote_q[0],
                   vote_q[1] | vote_q[0], vote_q[1] & vote_q[0], vote_q[1] & vote_q[0],
                   1'b0};

   mux u_mux (
      .sel_i (vote_q[4:2]),
      .d_i   (mux_d),
      .y_o   (mux_y)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      vote_d      = vote_q;
      res_out_d   = res_out_q;
      res_count_d = res_count_q;
      res_id_d    = res_id_q;
      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               vote_d  = req_data[5*grant_idx +: 5];
               id_d    = grant_idx;
               ptr_d   = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
               state_d = S_EVAL;
            end
         end
         S_EVAL: begin
            res_out_d   = mux_y;
            res_count_d = popcount5(vote_q);
            res_id_d    = id_q;
            state_d     = S_RESULT;
         end
         S_RESULT: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         vote_q      <= '0;
         res_out_q   <= 1'b0;
         res_count_q <= '0;
         res_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         vote_q      <= vote_d;
         res_out_q   <= res_out_d;
         res_count_q <= res_count_d;
         res_id_q    <= res_id_d;
      end
   end

   assign res_valid = (state_q == S_RESULT);
   assign res_out   = res_out_q;
   assign res_count = res_count_q;
   assign res_id    = res_id_q;

endmodule

// File: tb/tb_majority_vote_arbiter.sv
// Randomised and directed stimulus for majority_vote_arbiter, checked by a
// queue-based scoreboard fed from a transaction-level reference model.

module tb_majority_vote_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [5*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              res_valid;
   logic              res_ready;
   logic              res_out;
   logic [2:0]        res_count;
   logic [IDW-1:0]    res_id;

   always #5 clk = ~clk;

   majority_vote_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_out   (res_out),
      .res_count (res_count),
      .res_id    (res_id)
   );

   typedef struct packed {
      logic       o;
      logic [2:0] c;
      logic [1:0] id;
   } res_t;

   res_t expq[$];
   int   total = 0;
   int   bad = 0;
   int   m_ptr = 0;
   int   m_phase = 0;     // 0 waiting for grant, 1 evaluating, 2 result pending
   logic prev_reset = 1'b1;
   int   last_grant = -1;
   int   grants[$];

   function automatic res_t ref_result(input logic [4:0] v, input int id);
      res_t r;
      int   ones;
      ones = 0;
      for (int i = 0; i < 5; i++) ones += int'(v[i]);
      r.o  = (ones >= 3);
      r.c  = ones[2:0];
      r.id = id[1:0];
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      int w;
      int exp_ready;
      @(negedge clk);
      last_grant = -1;
      if (reset) begin
         chk("reset_req_ready", int'(req_ready), 0);
         if (prev_reset)
            chk("reset_res_zero", int'({res_valid, res_out, res_count, res_id}), 0);
         m_ptr   = 0;
         m_phase = 0;
         expq.delete();
      end else begin
         w = -1;
         for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
         end
         exp_ready = (m_phase == 0 && w >= 0) ? (1 << w) : 0;
         chk("req_ready", int'(req_ready), exp_ready);
         chk("res_valid", int'(res_valid), int'(m_phase == 2));
         case (m_phase)
            0: if (w >= 0) begin
                  expq.push_back(ref_result(req_data[5*w +: 5], w));
                  m_ptr      = (w + 1) % NREQ;
                  m_phase    = 1;
                  last_grant = w;
                  grants.push_back(w);
               end
            1: m_phase = 2;
            default: if (res_ready) m_phase = 0;
         endcase
      end
      prev_reset = reset;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input int who, input string name);
      for (int n = 0; n < 20; n++) begin
         step();
         if (last_grant == who) return;
      end
      total++;
      bad++;
      $display("FAIL %s: got no grant expected grant to %0d", name, who);
   endtask

   task automatic drain();
      req_valid = '0;
      res_ready = 1'b1;
      repeat (5) step();
   endtask

   // Result monitor: the front of the queue must be shown while res_valid is high.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && res_valid) begin
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_result: got id %0d expected no result", res_id);
            end else begin
               chk("result", int'({res_out, res_count, res_id}), int'(expq[0]));
               if (res_ready) void'(expq.pop_front());
            end
         end
      end
   end

   initial begin
      reset     = 1'b1;
      req_valid = '1;
      req_data  = 20'($urandom);
      res_ready = 1'b1;
      step();
      step();
      reset = 1'b0;

      // Full load: round-robin grant order
      grants.delete();
      for (int c = 0; c < 20; c++) begin
         if (last_grant >= 0) req_data[5*last_grant +: 5] = 5'($urandom);
         step();
      end
      if (grants.size() >= 6) begin
         for (int i = 0; i < 6; i++) chk("fair_order", grants[i], i % NREQ);
      end else begin
         chk("fair_count", grants.size(), 6);
      end
      drain();

      // Single request from requester 2
      req_valid = 4'b0100;
      req_data[14:10] = 5'b10110;
      wait_grant(2, "single_grant");
      req_valid = '0;
      repeat (4) step();

      // Every vector through requester 0
      for (int v = 0; v < 32; v++) begin
         req_valid = 4'b0001;
         req_data[4:0] = 5'(v);
         wait_grant(0, "exhaustive_grant");
         req_valid = '0;
      end
      drain();

      // Backpressure on the result channel
      req_valid = 4'b0010;
      req_data[9:5] = 5'b11001;
      res_ready = 1'b0;
      wait_grant(1, "bp_grant");
      req_valid = 4'b1111;
      repeat (7) step();
      req_valid = '0;
      res_ready = 1'b1;
      step();
      drain();

      // Reset while requester 3 is being evaluated
      req_valid = 4'b1000;
      req_data[19:15] = 5'b11100;
      wait_grant(3, "midreset_grant");
      req_valid = '0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (6) step();
      req_valid = 4'b1111;
      wait_grant(0, "post_reset_grant");
      drain();

      // Random traffic with random backpressure and withdrawn requests
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  req_valid[i] = 1'b1;
                  req_data[5*i +: 5] = 5'($urandom);
               end
            end else if (last_grant == i) begin
               if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
               else req_data[5*i +: 5] = 5'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         res_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain();
      chk("queue_empty", expq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
